// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//
// Load-use hazard detection and operand-forwarding select generation for a
// classic five-stage pipeline. The unit shadows the EX, MEM and WB stages with
// small tracking slots. It asks IF/ID to stall when the instruction in ID needs
// a load result that is not yet available. It also produces registered ALU
// operand selects for the instruction that is currently in EX.
//
// Parameters
//   OP_ALU  : R-type opcode  (writes rd, reads rs and rt)
//   OP_LW   : load           (writes rt, reads rs)
//   OP_SW   : store          (reads rs and rt, no write)
//   OP_ADDI : add-immediate  (writes rt, reads rs)
//   OP_J    : jump           (no read, no write)
//   OP_JAL  : jump-and-link  (writes r31, no read)
//
// Ports
//   clock        : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   id_valid     : ID stage holds an instruction
//   id_op        : ID opcode
//   id_rs/rt/rd  : ID register fields
//   flush        : squash the ID instruction (taken jump)
//   stall        : combinational load-use stall request to IF/ID
//   issue        : ID instruction moves into EX this cycle
//   fwd_a/fwd_b  : registered ALU operand selects for EX
//                  (00 register file, 01 MEM/WB, 10 EX/MEM)
//   stall_count  : saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter logic [5:0] OP_ALU  = 6'd0,
  parameter logic [5:0] OP_LW   = 6'd35,
  parameter logic [5:0] OP_SW   = 6'd43,
  parameter logic [5:0] OP_ADDI = 6'd8,
  parameter logic [5:0] OP_J    = 6'd2,
  parameter logic [5:0] OP_JAL  = 6'd3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        flush,
  output logic        stall,
  output logic        issue,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_count
);

  // Select encoding shared by fwd_a and fwd_b.
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_EX  = 2'b10;

  // One tracked pipeline stage: what the instruction occupying it will write.
  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       ld;
    logic [4:0] dst;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  slot_t ex_q, mem_q, wb_q;
  slot_t id_dec;
  logic  use_rs, use_rt;
  logic  ld_hit;
  logic  [1:0] fwd_a_d, fwd_b_d;

  // ---------------------------------------------------------------------------
  // Decode the ID instruction: destination and which source fields it reads.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    id_dec = BUBBLE;
    use_rs = 1'b0;
    use_rt = 1'b0;

    case (id_op)
      OP_ALU: begin
        id_dec.wr  = 1'b1;
        id_dec.dst = id_rd;
        use_rs     = 1'b1;
        use_rt     = 1'b1;
      end
      OP_LW: begin
        id_dec.wr  = 1'b1;
        id_dec.ld  = 1'b1;
        id_dec.dst = id_rt;
        use_rs     = 1'b1;
      end
      OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_ADDI: begin
        id_dec.wr  = 1'b1;
        id_dec.dst = id_rt;
        use_rs     = 1'b1;
      end
      OP_JAL: begin
        id_dec.wr  = 1'b1;
        id_dec.dst = 5'd31;
      end
      default: begin
        // OP_J and unknown opcodes neither read nor write registers.
      end
    endcase

    // r0 is hard-wired zero: a write to it is never a forwarding source and
    // never a hazard, so treat it as no write at all.
    if (id_dec.dst == 5'd0) begin
      id_dec.wr = 1'b0;
      id_dec.ld = 1'b0;
    end

    id_dec.valid = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard: the load in EX produces its data only at the end of MEM,
  // so a dependent instruction in ID must wait one cycle. Flush wins: a
  // squashed instruction never needs to wait.
  // ---------------------------------------------------------------------------
  assign ld_hit = ex_q.valid && ex_q.wr && ex_q.ld &&
                  ((use_rs && (ex_q.dst == id_rs)) ||
                   (use_rt && (ex_q.dst == id_rt)));

  // reset_n gates both strobes so nothing leaks out while the unit is held.
  assign stall = reset_n && id_valid && !flush && ld_hit;
  assign issue = reset_n && id_valid && !stall && !flush;

  // ---------------------------------------------------------------------------
  // Forwarding select for one source field. The selects are computed while the
  // instruction is in ID and take effect one cycle later when it is in EX. At
  // that point the current EX occupant sits in EX/MEM and the current MEM
  // occupant sits in MEM/WB. The youngest producer (EX slot) wins.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic       used,
                                         input logic [4:0] src,
                                         input slot_t      ex,
                                         input slot_t      mem);
    logic [1:0] sel;
    sel = SEL_RF;
    if (used) begin
      if (ex.valid && ex.wr && (ex.dst == src)) begin
        sel = SEL_EX;
      end else if (mem.valid && mem.wr && (mem.dst == src)) begin
        sel = SEL_MEM;
      end
    end
    return sel;
  endfunction

  assign fwd_a_d = fwd_sel(use_rs, id_rs, ex_q, mem_q);
  assign fwd_b_d = fwd_sel(use_rt, id_rt, ex_q, mem_q);

  // ---------------------------------------------------------------------------
  // Slot advance, registered selects and stall statistics.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so each slot samples
  // its predecessor's old value and the shift happens as a real pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the whole slot is cleared, not just valid, so the reset state is
      // fully defined. Clearing valid alone would be enough for correct
      // behaviour.
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      fwd_a       <= SEL_RF;
      fwd_b       <= SEL_RF;
      stall_count <= 16'd0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= issue ? id_dec : BUBBLE;

      // A bubble in EX must not steer the ALU from a stale forwarding path.
      fwd_a <= issue ? fwd_a_d : SEL_RF;
      fwd_b <= issue ? fwd_b_d : SEL_RF;

      if (stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
//
// Self-checking bench for hazard_fwd_unit. A reference model keeps a short
// history of what entered EX (youngest first). From the opcode rules it
// derives stall, issue, the next selects and the stall counter, and then
// compares these against the design under directed and random stimulus.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_unit;

  localparam logic [5:0] OP_ALU  = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush;
  logic        stall, issue;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  hazard_fwd_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .id_op       (id_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .flush       (flush),
    .stall       (stall),
    .issue       (issue),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: history of instructions that entered EX, index 0 = EX,
  // 1 = MEM, 2 = WB. dst = -1 means "writes nothing".
  // ---------------------------------------------------------------------------
  typedef struct {
    int dst;
    bit ld;
  } ent_t;

  ent_t hist[$];
  int   m_count;
  int   m_fwd_a, m_fwd_b;
  bit   last_stall;

  function automatic int dst_of(logic [5:0] op, logic [4:0] rt, logic [4:0] rd);
    int d;
    if (op == OP_ALU)                       d = rd;
    else if (op == OP_LW || op == OP_ADDI)  d = rt;
    else if (op == OP_JAL)                  d = 31;
    else                                    d = -1;
    return (d == 0) ? -1 : d;
  endfunction

  function automatic bit reads_rs(logic [5:0] op);
    return op == OP_ALU || op == OP_LW || op == OP_SW || op == OP_ADDI;
  endfunction

  function automatic bit reads_rt(logic [5:0] op);
    return op == OP_ALU || op == OP_SW;
  endfunction

  // Where will an operand come from once this instruction is in EX?
  function automatic int model_sel(bit used, int src);
    if (!used) return 0;
    if (hist.size() > 0 && hist[0].dst == src) return 2;
    if (hist.size() > 1 && hist[1].dst == src) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_count = 0;
    m_fwd_a = 0;
    m_fwd_b = 0;
  endfunction

  function automatic void model_push(bit iss, int dst, bit ld);
    ent_t e;
    e.dst = iss ? dst : -1;
    e.ld  = iss && ld;
    hist.push_front(e);
    if (hist.size() > 3) void'(hist.pop_back());
  endfunction

  // One full clock cycle: drive at the falling edge, check the combinational
  // strobes just after, clock the model at the rising edge, and check the
  // registered outputs at the next falling edge.
  task automatic cycle(input bit v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input bit fl);
    bit e_stall, e_issue;
    int d;
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
    #1;
    d = dst_of(op, rt, rd);
    e_stall = v && !fl && hist.size() > 0 && hist[0].ld && hist[0].dst >= 0 &&
              ((reads_rs(op) && hist[0].dst == int'(rs)) ||
               (reads_rt(op) && hist[0].dst == int'(rt)));
    e_issue = v && !e_stall && !fl;
    check("stall", stall, e_stall);
    check("issue", issue, e_issue);
    last_stall = stall;
    @(posedge clock);
    if (e_stall && m_count < 65535) m_count++;
    m_fwd_a = e_issue ? model_sel(reads_rs(op), rs) : 0;
    m_fwd_b = e_issue ? model_sel(reads_rt(op), rt) : 0;
    model_push(e_issue, d, op == OP_LW);
    @(negedge clock);
    check("fwd_a", fwd_a, m_fwd_a);
    check("fwd_b", fwd_b, m_fwd_b);
    check("stall_count", stall_count, m_count);
  endtask

  logic [5:0] ops [7] = '{OP_ALU, OP_LW, OP_SW, OP_ADDI, OP_J, OP_JAL, 6'd13};

  initial begin
    model_reset();
    reset_n = 1'b0;
    id_valid = 1'b1; id_op = OP_ALU; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
    flush = 1'b0;
    #3;
    check("rst_stall", stall, 0);
    check("rst_issue", issue, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check("rst_count", stall_count, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Back-to-back dependency: EX/MEM forward on A.
    cycle(1, OP_ALU, 5'd1, 5'd2, 5'd3, 0);
    cycle(1, OP_ALU, 5'd3, 5'd5, 5'd4, 0);
    check("r34_fwd_a", fwd_a, 2);
    check("r34_fwd_b", fwd_b, 0);

    // Two-apart dependency: MEM/WB forward on B.
    cycle(1, OP_ALU, 5'd1, 5'd2, 5'd3, 0);
    cycle(1, OP_ALU, 5'd10, 5'd11, 5'd9, 0);
    cycle(1, OP_ALU, 5'd12, 5'd3, 5'd13, 0);
    check("r35_fwd_b", fwd_b, 1);

    // Load-use: one stall, one bubble, then MEM/WB forward.
    cycle(1, OP_LW, 5'd1, 5'd7, 5'd0, 0);
    cycle(1, OP_ALU, 5'd7, 5'd8, 5'd9, 0);
    check("r36_stall", last_stall, 1);
    check("r36_bubble_fwd", fwd_a, 0);
    cycle(1, OP_ALU, 5'd7, 5'd8, 5'd9, 0);
    check("r36_unstall", last_stall, 0);
    check("r36_fwd_a", fwd_a, 1);
    check("r36_count", stall_count, 1);

    // Flush beats stall.
    cycle(1, OP_LW, 5'd1, 5'd7, 5'd0, 0);
    cycle(1, OP_SW, 5'd2, 5'd7, 5'd0, 1);
    check("r37_stall", last_stall, 0);
    check("r37_count", stall_count, 1);

    // r0 never forwarded; JAL forwards r31.
    cycle(1, OP_ALU, 5'd1, 5'd2, 5'd0, 0);
    cycle(1, OP_ALU, 5'd0, 5'd4, 5'd5, 0);
    check("r38_r0", fwd_a, 0);
    cycle(1, OP_JAL, 5'd0, 5'd0, 5'd0, 0);
    cycle(1, OP_ALU, 5'd31, 5'd1, 5'd6, 0);
    check("r38_jal", fwd_a, 2);

    // Random traffic over a small register window so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 85, ops[$urandom_range(6)],
            5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
            $urandom_range(99) < 10);
    end

    // Saturation: hold the stall request high far beyond the counter range.
    id_valid = 1'b0; flush = 1'b0;
    force dut.stall = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clock);
      if (m_count < 65535) m_count++;
      m_fwd_a = 0;
      m_fwd_b = 0;
      model_push(0, -1, 0);
    end
    @(negedge clock);
    release dut.stall;
    #1;
    check("sat_count", stall_count, 16'hFFFF);
    check("sat_fwd_a", fwd_a, 0);

    // Asynchronous reset mid-stream while a forward is active.
    @(negedge clock);
    cycle(1, OP_ALU, 5'd1, 5'd2, 5'd3, 0);
    cycle(1, OP_ALU, 5'd3, 5'd3, 5'd4, 0);
    check("pre_rst_fwd_a", fwd_a, 2);
    id_valid = 1'b1; id_op = OP_ALU; id_rs = 5'd4; id_rt = 5'd4; id_rd = 5'd6;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_fwd_a", fwd_a, 0);
    check("arst_fwd_b", fwd_b, 0);
    check("arst_count", stall_count, 0);
    check("arst_stall", stall, 0);
    check("arst_issue", issue, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1, OP_ALU, 5'd4, 5'd3, 5'd6, 0);
    check("post_rst_fwd_a", fwd_a, 0);
    check("post_rst_fwd_b", fwd_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter OP_ALU, default 6'd0, meaning R-type opcode; writes rd and reads rs and rt.
REQ-002 SHALL have parameter OP_LW, default 6'd35, meaning load; writes rt and reads rs.
REQ-003 SHALL have parameter OP_SW, default 6'd43, meaning store; reads rs and rt; no register write.
REQ-004 SHALL have parameter OP_ADDI, default 6'd8, meaning add-immediate; writes rt and reads rs.
REQ-005 SHALL have parameter OP_J, default 6'd2, meaning jump; no register read or write.
REQ-006 SHALL have parameter OP_JAL, default 6'd3, meaning jump-and-link; writes r31; no register read.
REQ-007 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port id_valid, input, 1, meaning the ID stage holds an instruction.
REQ-010 SHALL have port id_op, input, 6, meaning the ID opcode.
REQ-011 SHALL have ports id_rs, id_rt and id_rd, input, 5 each, meaning the ID register fields.
REQ-012 SHALL have port flush, input, 1, meaning squash the ID instruction (taken jump).
REQ-013 SHALL have port stall, output, 1, combinational load-use stall request to IF/ID.
REQ-014 SHALL have port issue, output, 1, equal to id_valid & !stall & !flush.
REQ-015 SHALL have port fwd_a, output, 2, registered ALU-input-A select for the instruction in EX: 00 register file, 01 MEM/WB, 10 EX/MEM.
REQ-016 SHALL have port fwd_b, output, 2, the same encoding as fwd_a, for ALU input B.
REQ-017 SHALL have port stall_count, output, 16, the saturating count of stall cycles.

Function
REQ-018 SHALL hold three tracking slots, EX, MEM and WB, each with valid, wr (writes a register), ld (is a load) and dst[4:0].
REQ-019 SHALL decode the destination as: rd for OP_ALU; rt for OP_LW and OP_ADDI; 5'd31 for OP_JAL; wr=0 for all other opcodes.
REQ-020 SHALL force wr=0 for any instruction whose dst is 0 (r0 never forwarded, never causes a stall).
REQ-021 SHALL advance the slots every cycle: WB<=MEM, MEM<=EX, EX<=decoded ID instruction if issue, else a bubble (valid=0).
REQ-022 SHALL treat rs as used for OP_ALU, OP_LW, OP_SW and OP_ADDI, and rt as used for OP_ALU and OP_SW only.
REQ-023 SHALL assert stall when id_valid & !flush & EX.valid & EX.wr & EX.ld and EX.dst equals a used source field.
REQ-024 SHALL compute the next fwd_a as: 10 if EX.valid&EX.wr&EX.dst==id_rs; else 01 if MEM.valid&MEM.wr&MEM.dst==id_rs; else 00 (the EX slot has priority).
REQ-025 SHALL compute the next fwd_b identically using id_rt.
REQ-026 SHALL force the next select to 00 for an unused source field.
REQ-027 SHALL register fwd_a and fwd_b on issue, and load 00 on any non-issue cycle.
REQ-028 SHALL give flush priority over stall: when flush=1, stall=0, issue=0 and the EX slot receives a bubble.
REQ-029 SHALL increment stall_count by 1 on each cycle with stall=1, and hold it at 16'hFFFF with no wrap.
REQ-030 SHALL resolve a stall in exactly one cycle, because the load moves to MEM and the retried instruction then gets fwd=01.

Reset
REQ-031 SHALL clear all slot valid bits, and set fwd_a=00, fwd_b=00 and stall_count=0, asynchronously while reset_n=0.
REQ-032 SHALL keep stall=0 and issue=0 during reset regardless of id_valid.
REQ-033 SHALL drop in-flight slots when reset is applied mid-operation; the first instruction after release sees fwd=00.

Verification
REQ-034 SHALL verify ALU r3<-r1+r2, then ALU r4<-r3+r5 on the next cycle -> second instruction in EX with fwd_a=10, fwd_b=00, stall never 1.
REQ-035 SHALL verify ALU writing r3, an unrelated instruction, then ALU reading rt=r3 -> fwd_b=01 when the third instruction is in EX.
REQ-036 SHALL verify LW r7, then ALU reading rs=r7 -> stall=1 for exactly 1 cycle, one bubble, then fwd_a=01, stall_count=1.
REQ-037 SHALL verify LW r7, then SW using rt=r7 with flush=1 in the same cycle -> stall=0, issue=0, stall_count unchanged.
REQ-038 SHALL verify ALU writing r0, then ALU reading r0 -> fwd_a=00; JAL, then ALU reading rs=r31 -> fwd_a=10.
REQ-039 SHALL verify that forcing 65540 stall cycles gives stall_count=16'hFFFF, and that asserting reset_n=0 mid-stream clears all outputs asynchronously.
